i2c_slave_core: RTL

// Synthesizable 7-bit-address I2C target: the responder for the bench's I2C master model.

---
 rtl/i2c_slave_core_if.sv | 34 +++
 rtl/i2c_slave_core.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_core_if.sv
// i2c_slave_core_if
// Bundles the I2C pins and the byte-level handshake of the I2C target core.
//   scl_i, sda_i    bus SCL and wired-AND SDA as seen at the pins (asynchronous)
//   sda_o           open-drain SDA drive: 0 = pull low, 1 = release
//   rx_data         last byte written by the master, valid with rx_valid
//   rx_valid        1-clk pulse, new rx_data
//   tx_data         next byte to return on a read
//   tx_req          1-clk pulse, tx_data is needed before the next SCL fall
//   addr_match      1-clk pulse when the address byte matched
//   rw              R/W bit of the current matched transfer (1 = read)
//   busy            core is not idle
// The slave modport is the core's view; the master modport is the bus-side view.
interface i2c_slave_core_if;
    logic       scl_i;
    logic       sda_i;
    logic       sda_o;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_req;
    logic       addr_match;
    logic       rw;
    logic       busy;

    modport slave (
        input  scl_i, sda_i, tx_data,
        output sda_o, rx_data, rx_valid, tx_req, addr_match, rw, busy
    );

    modport master (
        output scl_i, sda_i, tx_data,
        input  sda_o, rx_data, rx_valid, tx_req, addr_match, rw, busy
    );
endinterface

// File: rtl/i2c_slave_core.sv
// i2c_slave_core
// 7-bit-address I2C target without clock stretching. SCL/SDA are oversampled with clk,
// START/STOP and SCL edges are derived from the synchronized samples, and SDA is
// driven open-drain. Written bytes appear on rx_data/rx_valid; read bytes are taken
// from tx_data, requested one byte ahead with tx_req.
//   clk   system clock, at least 20x the SCL rate
//   rst   synchronous reset, active-high
//   bus   i2c_slave_core_if.slave (pins plus byte handshake)
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for START
// ADDR      | shifting the address byte; ACK decided on the following fall
// ADDR_ACK  | driving the address ACK
// WR_DATA   | shifting a written byte
// WR_ACK    | driving the ACK for a written byte
// RD_DATA   | driving a read byte, MSB first
// RD_ACK    | released SDA, sampling the master's ACK/NACK
// WAIT_STOP | not addressed or master NACKed; ignore bus until START/STOP
module i2c_slave_core #(
    parameter logic [6:0] SLAVE_ADDR  = 7'h3A,
    parameter int         SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    i2c_slave_core_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        WR_DATA,
        WR_ACK,
        RD_DATA,
        RD_ACK,
        WAIT_STOP
    } state_t;

    logic [SYNC_STAGES-1:0] scl_sync_q;
    logic [SYNC_STAGES-1:0] sda_sync_q;
    logic                   scl_h_q;
    logic                   sda_h_q;

    logic scl_s;
    logic sda_s;
    logic scl_rise;
    logic scl_fall;
    logic start_ev;
    logic stop_ev;

    state_t     state_q;
    logic [2:0] bit_cnt_q;
    // Only 7 bits are stored: the 8th bit of a byte is taken straight from sda_s.
    logic [6:0] shreg_q;
    logic       byte_done_q;
    logic       addr_ok_q;
    logic       ack_q;
    logic       sda_q;
    logic [7:0] rx_data_q;
    logic       rx_valid_q;
    logic       tx_req_q;
    logic       addr_match_q;
    logic       rw_q;

    // Synchronizers plus one history stage. Reset to the idle bus level.
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_h_q    <= 1'b1;
            sda_h_q    <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], bus.scl_i};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], bus.sda_i};
            scl_h_q    <= scl_sync_q[SYNC_STAGES-1];
            sda_h_q    <= sda_sync_q[SYNC_STAGES-1];
        end
    end

    assign scl_s    = scl_sync_q[SYNC_STAGES-1];
    assign sda_s    = sda_sync_q[SYNC_STAGES-1];
    assign scl_rise = scl_s & ~scl_h_q;
    assign scl_fall = ~scl_s & scl_h_q;
    assign start_ev = scl_s & sda_h_q & ~sda_s;
    assign stop_ev  = scl_s & ~sda_h_q & sda_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            bit_cnt_q    <= 3'd0;
            shreg_q      <= 7'd0;
            byte_done_q  <= 1'b0;
            addr_ok_q    <= 1'b0;
            ack_q        <= 1'b0;
            sda_q        <= 1'b1;
            rx_data_q    <= 8'd0;
            rx_valid_q   <= 1'b0;
            tx_req_q     <= 1'b0;
            addr_match_q <= 1'b0;
            rw_q         <= 1'b0;
        end else begin
            rx_valid_q   <= 1'b0;
            tx_req_q     <= 1'b0;
            addr_match_q <= 1'b0;

            // START/STOP override whatever byte is in progress.
            if (start_ev) begin
                state_q     <= ADDR;
                bit_cnt_q   <= 3'd0;
                byte_done_q <= 1'b0;
                ack_q       <= 1'b0;
                sda_q       <= 1'b1;
            end else if (stop_ev) begin
                state_q     <= IDLE;
                bit_cnt_q   <= 3'd0;
                byte_done_q <= 1'b0;
                ack_q       <= 1'b0;
                sda_q       <= 1'b1;
            end else begin
                case (state_q)
                    IDLE: begin
                        sda_q <= 1'b1;
                    end

                    ADDR: begin
                        if (scl_rise) begin
                            shreg_q   <= {shreg_q[5:0], sda_s};
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) begin
                                byte_done_q <= 1'b1;
                                // shreg_q already holds address bits 6..0; sda_s is R/W.
                                if (shreg_q == SLAVE_ADDR) begin
                                    addr_ok_q    <= 1'b1;
                                    rw_q         <= sda_s;
                                    addr_match_q <= 1'b1;
                                    tx_req_q     <= sda_s;
                                end else begin
                                    addr_ok_q <= 1'b0;
                                end
                            end
                        end else if (scl_fall && byte_done_q) begin
                            byte_done_q <= 1'b0;
                            if (addr_ok_q) begin
                                sda_q   <= 1'b0;
                                state_q <= ADDR_ACK;
                            end else begin
                                state_q <= WAIT_STOP;
                            end
                        end
                    end

                    ADDR_ACK: begin
                        if (scl_fall) begin
                            bit_cnt_q <= 3'd0;
                            if (rw_q) begin
                                shreg_q <= bus.tx_data[6:0];
                                sda_q   <= bus.tx_data[7];
                                state_q <= RD_DATA;
                            end else begin
                                sda_q   <= 1'b1;
                                state_q <= WR_DATA;
                            end
                        end
                    end

                    WR_DATA: begin
                        if (scl_rise) begin
                            shreg_q   <= {shreg_q[5:0], sda_s};
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) begin
                                rx_data_q   <= {shreg_q, sda_s};
                                rx_valid_q  <= 1'b1;
                                byte_done_q <= 1'b1;
                            end
                        end else if (scl_fall && byte_done_q) begin
                            byte_done_q <= 1'b0;
                            sda_q       <= 1'b0;
                            state_q     <= WR_ACK;
                        end
                    end

                    WR_ACK: begin
                        if (scl_fall) begin
                            sda_q   <= 1'b1;
                            state_q <= WR_DATA;
                        end
                    end

                    RD_DATA: begin
                        if (scl_rise) begin
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) begin
                                byte_done_q <= 1'b1;
                            end
                        end else if (scl_fall) begin
                            if (byte_done_q) begin
                                byte_done_q <= 1'b0;
                                ack_q       <= 1'b0;
                                sda_q       <= 1'b1;
                                state_q     <= RD_ACK;
                            end else begin
                                sda_q   <= shreg_q[6];
                                shreg_q <= {shreg_q[5:0], 1'b0};
                            end
                        end
                    end

                    RD_ACK: begin
                        if (scl_rise) begin
                            if (!sda_s) begin
                                ack_q    <= 1'b1;
                                tx_req_q <= 1'b1;
                            end else begin
                                state_q <= WAIT_STOP;
                            end
                        end else if (scl_fall && ack_q) begin
                            ack_q     <= 1'b0;
                            bit_cnt_q <= 3'd0;
                            shreg_q   <= bus.tx_data[6:0];
                            sda_q     <= bus.tx_data[7];
                            state_q   <= RD_DATA;
                        end
                    end

                    WAIT_STOP: begin
                        sda_q <= 1'b1;
                    end

                    default: begin
                        sda_q   <= 1'b1;
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.sda_o      = sda_q;
    assign bus.rx_data    = rx_data_q;
    assign bus.rx_valid   = rx_valid_q;
    assign bus.tx_req     = tx_req_q;
    assign bus.addr_match = addr_match_q;
    assign bus.rw         = rw_q;
    assign bus.busy       = (state_q != IDLE);

endmodule
